program_counter_unit: RTL and testbench
=======================================

// Module: program_counter_unit
// PURPOSE
//  Parametrised program counter for the CPU fetch stage; successor to the plain 8-bit loadable PC.
//  Each clock it selects the next fetch address from one of: hold, sequential increment,
//  absolute jump, signed relative branch, subroutine call or return.
//  Holds an internal LIFO return-address stack that backs call/return.
//  Feeds the instruction-memory address; the decode/branch unit drives the control inputs.
// PARAMETERS
//  ADDR_W      8    width of pc, load_addr, branch_off (bits)
//  STACK_DEPTH 4    return-stack entries (>=1, power of 2 not required)
//  RESET_ADDR  0    pc value after reset
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous reset, active-high
//  stall       in   1            hold pc and stack unchanged
//  load        in   1            absolute jump to load_addr
//  load_addr   in   ADDR_W       jump/call target
//  branch_en   in   1            relative branch: pc <= pc + branch_off
//  branch_off  in   ADDR_W       signed two's-complement offset
//  call        in   1            push pc+1, jump to load_addr
//  ret         in   1            pop top of stack into pc
//  pc          out  ADDR_W       current fetch address (registered)
//  stack_full  out  1            stack holds STACK_DEPTH entries
//  stack_empty out  1            stack holds 0 entries
//  overflow    out  1            sticky: call attempted while full
//  underflow   out  1            sticky: ret attempted while empty
// BEHAVIOUR
//  - Reset (async, any time, including mid-call/return):
//    pc=RESET_ADDR, stack count=0, stack_empty=1, stack_full=0, overflow=0, underflow=0.
//    Stack contents are don't-care after reset.
//  - All updates happen on the rising clk edge; inputs are sampled at that edge.
//    The new pc is visible one cycle later. No combinational path from inputs to pc.
//  - Priority per edge, highest first: stall > ret > call > load > branch_en > increment.
//    Lower-priority requests asserted in the same cycle are ignored.
//  - stall: pc, stack, and flags all hold.
//  - ret, count>0: pc <= stack[top]; count--.
//  - ret, count==0: pc <= pc+1; underflow <= 1; count unchanged.
//  - call, count<DEPTH: stack[count] <= pc+1; count++; pc <= load_addr.
//  - call, count==DEPTH: no push, no jump; pc <= pc+1; overflow <= 1.
//  - load: pc <= load_addr.
//  - branch_en: pc <= pc + branch_off, modulo 2^ADDR_W.
//  - No request: pc <= pc+1, modulo 2^ADDR_W (all-ones wraps to 0).
//  - All arithmetic is ADDR_W bits wide; carries are discarded; the pushed pc+1 also wraps.
//  - overflow and underflow stay set until rst.
//  - stack_full and stack_empty are decoded from the registered count, so they are valid
//    in the same cycle as pc.
// STRUCTURE
//  - pc_pkg: constants PC_ADDR_W_DEFAULT=8 and PC_STACK_DEPTH_DEFAULT=4, plus a localparam
//    encoding for the selected next-pc source (HOLD, RET, CALL, LOAD, BRANCH, INC).
//  - Sub-module return_stack (params W, DEPTH): push/pop/top/count/full/empty,
//    async active-high reset on count.
//  - Top level: priority encoder, next-pc mux, pc register, sticky error flags.
// TESTING
//  1. rst=1, then release with no requests for 4 clks
//     -> pc 0,1,2,3,4; stack_empty=1; overflow=underflow=0.
//  2. load=1, load_addr=55 for 1 clk, then idle; later load_addr=200
//     -> pc 55,56,... then 200,201.
//  3. Branch: pc=10, branch_off=8'hFB (-5) -> pc=5.
//     Branch: pc=8'hFE, branch_off=3 -> pc=1. Increment from 8'hFF -> pc=0.
//  4. At pc=20, call load_addr=100; at pc=101, call load_addr=150; then ret twice
//     -> pc 100, 101, 150, then 102, 21. Stack count 1,2,1,0. stack_empty=1 at end.
//  5. Five calls with DEPTH=4 -> 5th call: pc increments, overflow=1, stack_full=1.
//     Then 5 rets -> 4 pops in reverse order; 5th ret: underflow=1, pc increments.
//  6. Priority: stall+ret+call asserted -> pc holds. Then ret+call+load -> ret wins.
//     Then rst asserted mid-cycle after a call -> pc=RESET_ADDR and empty immediately,
//     without waiting for clk.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and next-pc source encoding for the fetch-stage program counter.
package pc_pkg;

   localparam int PC_ADDR_W_DEFAULT      = 8;
   localparam int PC_STACK_DEPTH_DEFAULT = 4;

   typedef logic [2:0] pc_src_t;

   localparam pc_src_t PC_SRC_HOLD   = 3'd0;
   localparam pc_src_t PC_SRC_RET    = 3'd1;
   localparam pc_src_t PC_SRC_CALL   = 3'd2;
   localparam pc_src_t PC_SRC_LOAD   = 3'd3;
   localparam pc_src_t PC_SRC_BRANCH = 3'd4;
   localparam pc_src_t PC_SRC_INC    = 3'd5;

   // Fixed priority: stall > ret > call > load > branch > increment.
   function automatic pc_src_t pc_select(
      input logic stall,
      input logic ret,
      input logic call,
      input logic load,
      input logic branch_en
   );
      pc_src_t src;
      src = PC_SRC_INC;
      if (stall)          src = PC_SRC_HOLD;
      else if (ret)       src = PC_SRC_RET;
      else if (call)      src = PC_SRC_CALL;
      else if (load)      src = PC_SRC_LOAD;
      else if (branch_en) src = PC_SRC_BRANCH;
      return src;
   endfunction

endpackage

// File: rtl/pc_if.sv
// Control/status bundle between the decode/branch unit (master) and the program counter (slave).
interface pc_if
   import pc_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W_DEFAULT
) ();

   logic              stall;
   logic              load;
   logic [ADDR_W-1:0] load_addr;
   logic              branch_en;
   logic [ADDR_W-1:0] branch_off;
   logic              call;
   logic              ret;
   logic [ADDR_W-1:0] pc;
   logic              stack_full;
   logic              stack_empty;
   logic              overflow;
   logic              underflow;

   modport master (
      output stall, load, load_addr, branch_en, branch_off, call, ret,
      input  pc, stack_full, stack_empty, overflow, underflow
   );

   modport slave (
      input  stall, load, load_addr, branch_en, branch_off, call, ret,
      output pc, stack_full, stack_empty, overflow, underflow
   );

endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses; count is reset asynchronously, entries are left untouched.
module return_stack #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     push_dat,
   output logic [W-1:0]     top,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0] mem [DEPTH];

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[IDX_W'(count)] <= push_dat;
      end
   end

   // Only meaningful while not empty; the wrapped index when empty is never consumed.
   assign top = mem[IDX_W'(count - CNT_W'(1))];

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: prioritised next-pc select, call/return stack, sticky stack errors.
module program_counter_unit
   import pc_pkg::*;
#(
   parameter int ADDR_W      = PC_ADDR_W_DEFAULT,
   parameter int STACK_DEPTH = PC_STACK_DEPTH_DEFAULT,
   parameter int RESET_ADDR  = 0
) (
   input logic clk,
   input logic rst,
   pc_if.slave bus
);

   localparam int CNT_W = $clog2(STACK_DEPTH + 1);

   pc_src_t           src;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] stk_top;
   logic [CNT_W-1:0]  stk_count;
   logic              stk_full;
   logic              stk_empty;
   logic              push;
   logic              pop;
   logic              ovf_q;
   logic              unf_q;

   assign src    = pc_select(bus.stall, bus.ret, bus.call, bus.load, bus.branch_en);
   assign pc_inc = pc_q + ADDR_W'(1);

   always_comb begin
      pc_d = pc_inc;
      push = 1'b0;
      pop  = 1'b0;
      case (src)
         PC_SRC_HOLD: pc_d = pc_q;
         PC_SRC_RET: begin
            if (!stk_empty) begin
               pc_d = stk_top;
               pop  = 1'b1;
            end
         end
         // A call into a full stack degrades to a plain increment.
         PC_SRC_CALL: begin
            if (!stk_full) begin
               pc_d = bus.load_addr;
               push = 1'b1;
            end
         end
         PC_SRC_LOAD:   pc_d = bus.load_addr;
         PC_SRC_BRANCH: pc_d = pc_q + bus.branch_off;
         default:       pc_d = pc_inc;
      endcase
   end

   return_stack #(
      .W     (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_dat (pc_inc),
      .top      (stk_top),
      .count    (stk_count),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= ADDR_W'(RESET_ADDR);
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         if (src == PC_SRC_CALL && stk_full) begin
            ovf_q <= 1'b1;
         end
         if (src == PC_SRC_RET && stk_empty) begin
            unf_q <= 1'b1;
         end
      end
   end

   count_in_range: assert property (@(posedge clk) disable iff (rst)
      stk_count <= CNT_W'(STACK_DEPTH));

   assign bus.pc          = pc_q;
   assign bus.stack_full  = stk_full;
   assign bus.stack_empty = stk_empty;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench: directed vector table, async-reset sequence, randomized run against a queue model.
module tb_program_counter_unit;

   logic clk;
   logic rst;

   pc_if #(.ADDR_W(8)) bus ();

   program_counter_unit #(
      .ADDR_W      (8),
      .STACK_DEPTH (4),
      .RESET_ADDR  (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       s, r, c, l, b;
      logic [7:0] la, off;
      logic [7:0] epc;
      logic       eempty, efull, eof, euf;
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int   mpc;
   int   mstk[$];
   bit   mof, muf;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic s, r, c, l, b, input logic [7:0] la, off, epc,
                      input logic em, fu, ov, un);
      vec_t v;
      v.s = s; v.r = r; v.c = c; v.l = l; v.b = b;
      v.la = la; v.off = off; v.epc = epc;
      v.eempty = em; v.efull = fu; v.eof = ov; v.euf = un;
      vq.push_back(v);
   endtask

   task automatic drive(input logic s, r, c, l, b, input logic [7:0] la, off);
      bus.stall = s; bus.ret = r; bus.call = c; bus.load = l; bus.branch_en = b;
      bus.load_addr = la; bus.branch_off = off;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int idx, input int epc,
                          input bit em, input bit fu, input bit ov, input bit un);
      chk({tag, "_pc"},    idx, 32'(bus.pc), epc);
      chk({tag, "_empty"}, idx, 32'(bus.stack_empty), 32'(em));
      chk({tag, "_full"},  idx, 32'(bus.stack_full), 32'(fu));
      chk({tag, "_ovf"},   idx, 32'(bus.overflow), 32'(ov));
      chk({tag, "_unf"},   idx, 32'(bus.underflow), 32'(un));
   endtask

   // Reference: stack as a queue, pc as an integer modulo 256.
   task automatic model(input bit s, r, c, l, b, input int la, off);
      if (s) return;
      if (r) begin
         if (mstk.size() > 0) mpc = mstk.pop_back();
         else begin mpc = (mpc + 1) % 256; muf = 1; end
      end else if (c) begin
         if (mstk.size() < 4) begin mstk.push_back((mpc + 1) % 256); mpc = la; end
         else begin mpc = (mpc + 1) % 256; mof = 1; end
      end else if (l) mpc = la;
      else if (b) mpc = (mpc + off) % 256;
      else mpc = (mpc + 1) % 256;
   endtask

   initial begin
      //  s  r  c  l  b  la      off    pc      em fu of uf
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd1,   1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd2,   1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd3,   1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd4,   1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'd55,  8'd0,  8'd55,  1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd56,  1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd57,  1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'd200, 8'd0,  8'd200, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd201, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'd10,  8'd0,  8'd10,  1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 8'd0,   8'hFB, 8'd5,   1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'hFE,  8'd0,  8'hFE,  1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 8'd0,   8'd3,  8'd1,   1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'hFF,  8'd0,  8'hFF,  1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd0,   1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'd20,  8'd0,  8'd20,  1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd100, 8'd0,  8'd100, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'd0,   8'd0,  8'd101, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd150, 8'd0,  8'd150, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd102, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd21,  1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd30,  8'd0,  8'd30,  0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd40,  8'd0,  8'd40,  0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd50,  8'd0,  8'd50,  0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd60,  8'd0,  8'd60,  0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 8'd70,  8'd0,  8'd61,  0, 1, 1, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd51,  0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd41,  0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd31,  0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd22,  1, 0, 1, 0);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd23,  1, 0, 1, 1);
      add(1, 1, 1, 0, 0, 8'd99,  8'd0,  8'd23,  1, 0, 1, 1);
      add(0, 0, 1, 0, 0, 8'd80,  8'd0,  8'd80,  0, 0, 1, 1);
      add(0, 1, 1, 1, 0, 8'd90,  8'd0,  8'd24,  1, 0, 1, 1);
      add(0, 0, 1, 1, 1, 8'd120, 8'd5,  8'd120, 0, 0, 1, 1);
      add(0, 0, 0, 1, 1, 8'd7,   8'd3,  8'd7,   0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 8'd0,   8'd3,  8'd10,  0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 8'd0,   8'd0,  8'd10,  0, 0, 1, 1);
      add(0, 1, 0, 0, 0, 8'd0,   8'd0,  8'd25,  1, 0, 1, 1);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
      repeat (2) step();
      chk_all("reset", 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].s, vq[i].r, vq[i].c, vq[i].l, vq[i].b, vq[i].la, vq[i].off);
         step();
         chk_all("vec", i, int'(vq[i].epc), vq[i].eempty, vq[i].efull, vq[i].eof, vq[i].euf);
      end

      // Asynchronous reset landing between edges right after a call.
      drive(0, 0, 1, 0, 0, 8'd33, 8'd0);
      step();
      chk("arst_call_pc", 0, 32'(bus.pc), 32'd33);
      chk("arst_call_empty", 0, 32'(bus.stack_empty), 32'd0);
      drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
      #3;
      rst = 1'b1;
      #1;
      chk_all("arst", 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("arst_release_pc", 0, 32'(bus.pc), 32'd1);

      mpc = 1;
      mstk.delete();
      mof = 0;
      muf = 0;
      for (int n = 0; n < 3000; n++) begin
         bit s, r, c, l, b;
         int la, off;
         s   = ($urandom_range(0, 99) < 10);
         r   = ($urandom_range(0, 99) < 25);
         c   = ($urandom_range(0, 99) < 25);
         l   = ($urandom_range(0, 99) < 10);
         b   = ($urandom_range(0, 99) < 25);
         la  = int'($urandom_range(0, 255));
         off = int'($urandom_range(0, 255));
         drive(s, r, c, l, b, 8'(la), 8'(off));
         model(s, r, c, l, b, la, off);
         step();
         chk_all("rnd", n, mpc, mstk.size() == 0, mstk.size() == 4, mof, muf);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
